// File: rtl/nla_mem_pkg.sv
// Shared definitions for NLA BRAM port logic: read latency, response depth floor,
// default-width request/response structs and a power-of-two helper.
// Ports: none (package).
package nla_mem_pkg;

  // Registered read latency of the no-change BRAM: address cycle -> output register.
  localparam int READ_LATENCY   = 2;
  // Smallest response queue that still sustains one read per cycle.
  localparam int RSP_DEPTH_MIN  = 4;

  localparam int RAM_WIDTH_DFLT  = 32;
  localparam int ADDR_LINES_DFLT = 4;

  typedef struct packed {
    logic                       we;
    logic [ADDR_LINES_DFLT-1:0] addr;
    logic [RAM_WIDTH_DFLT-1:0]  wdata;
  } mem_req_t;

  typedef struct packed {
    logic [RAM_WIDTH_DFLT-1:0] rdata;
  } mem_rsp_t;

  function automatic logic is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bram_port_initiator_if.sv
// Request/response streams between a BRAM port initiator and its client.
// master: client side (issues requests, consumes responses); slave: initiator side.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata, rsp_valid/rsp_ready/rsp_rdata, busy.
interface bram_port_initiator_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_LINES-1:0] req_addr;
  logic [RAM_WIDTH-1:0]  req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [RAM_WIDTH-1:0]  rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/sync_fifo_reg.sv
// Register-based synchronous FIFO, first-word-fall-through, with occupancy count.
// Latency: a push is visible on o_pop_dat/o_empty the cycle after; pop is applied at the clock edge.
// Backpressure: none internally; the caller must never push when full (asserted), pops on empty are ignored.
// Ports: clk_i, rstn (async active-low), i_push/i_push_dat, i_pop, o_pop_dat, o_count, o_empty.
module sync_fifo_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop     = i_pop && !o_empty;
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  // Payload storage needs no reset; validity comes from the count.
  always_ff @(posedge clk_i) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn) !(i_push && w_full));

endmodule

// File: rtl/bram_port_initiator.sv
// Initiator for one port of a no-change true dual-port BRAM: turns a valid/ready request stream into
// BRAM pin activity and returns read data in order. Latency: read accept -> rsp_valid is 3 cycles.
// Backpressure: requests are credited against reads in flight plus queued responses (RSP_DEPTH total).
// Ports: clk_i, rstn, s_if (slave modport: req/rsp streams + busy),
//        bram_en/we/addr/din/regce/rstn to the BRAM, bram_dout from it.
module bram_port_initiator
  import nla_mem_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  bram_port_initiator_if.slave  s_if,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_LINES-1:0] bram_addr,
  output logic [RAM_WIDTH-1:0]  bram_din,
  output logic                  bram_regce,
  output logic                  bram_rstn,
  input  logic [RAM_WIDTH-1:0]  bram_dout
);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_LINES-1:0] addr;
    logic [RAM_WIDTH-1:0]  wdata;
  } req_w_t;

  req_w_t                  w_req;
  logic                    w_req_rdy;
  logic                    w_req_acc;
  logic                    w_rd_acc;
  logic [SUM_W-1:0]        w_credit_used;
  logic                    w_fifo_push;
  logic                    w_fifo_pop;
  logic                    w_fifo_empty;
  logic [CNT_W-1:0]        w_fifo_cnt;
  logic [RAM_WIDTH-1:0]    w_fifo_dat;
  // Bit 0 = read issued last cycle (p1), bit READ_LATENCY-1 = data on bram_dout now (p2).
  logic [READ_LATENCY-1:0] r_rd_pipe;

  assign w_req = '{we: s_if.req_we, addr: s_if.req_addr, wdata: s_if.req_wdata};

  // Every in-flight read already owns a FIFO slot, so credit counts pipeline + queue.
  // Only registered state is used: a pop this cycle frees its slot next cycle.
  always_comb begin
    w_credit_used = SUM_W'(w_fifo_cnt);
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_credit_used = w_credit_used + SUM_W'(r_rd_pipe[i]);
    end
  end

  // Gated by rstn so nothing reaches the BRAM while reset is held.
  assign w_req_rdy = rstn && (w_credit_used < SUM_W'(RSP_DEPTH));
  assign w_req_acc = s_if.req_valid && w_req_rdy;
  assign w_rd_acc  = w_req_acc && !w_req.we;

  assign s_if.req_ready = w_req_rdy;
  assign bram_en        = w_req_acc;
  assign bram_we        = w_req.we;
  assign bram_addr      = w_req.addr;
  assign bram_din       = w_req.wdata;
  assign bram_rstn      = rstn;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe <= {r_rd_pipe[READ_LATENCY-2:0], w_rd_acc};
    end
  end

  // Output register captures the array latch one cycle after the read address.
  assign bram_regce  = r_rd_pipe[0];
  assign w_fifo_push = r_rd_pipe[READ_LATENCY-1];
  assign w_fifo_pop  = s_if.rsp_valid && s_if.rsp_ready;

  sync_fifo_reg #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rstn       (rstn),
    .i_push     (w_fifo_push),
    .i_push_dat (bram_dout),
    .i_pop      (w_fifo_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_count    (w_fifo_cnt),
    .o_empty    (w_fifo_empty)
  );

  assign s_if.rsp_valid = !w_fifo_empty;
  assign s_if.rsp_rdata = w_fifo_dat;
  assign s_if.busy      = (|r_rd_pipe) || (w_fifo_cnt != '0);

  a_depth_ok: assert property (@(posedge clk_i)
    is_pow2(RSP_DEPTH) && (RSP_DEPTH >= RSP_DEPTH_MIN));

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rstn)
    (s_if.rsp_valid && !s_if.rsp_ready) |=> (s_if.rsp_valid && $stable(s_if.rsp_rdata)));

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed + randomized bench for bram_port_initiator with a behavioural no-change BRAM.
// Inputs change 1 ns after posedge; outputs are sampled 2 ns after posedge.
// Summary line reports total comparisons and failures.
module tb_bram_port_initiator;
  import nla_mem_pkg::*;

  localparam int RW = 32;
  localparam int AL = 4;
  localparam int RD = 4;

  logic clk_i = 1'b0;
  logic rstn  = 1'b0;
  always #5 clk_i = ~clk_i;

  bram_port_initiator_if #(.RAM_WIDTH(RW), .ADDR_LINES(AL)) u_if ();

  logic          bram_en;
  logic          bram_we;
  logic [AL-1:0] bram_addr;
  logic [RW-1:0] bram_din;
  logic          bram_regce;
  logic          bram_rstn;
  logic [RW-1:0] bram_dout;

  bram_port_initiator #(
    .RAM_WIDTH  (RW),
    .ADDR_LINES (AL),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk_i      (clk_i),
    .rstn       (rstn),
    .s_if       (u_if),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_regce (bram_regce),
    .bram_rstn  (bram_rstn),
    .bram_dout  (bram_dout)
  );

  // No-change BRAM port: array read latch, then output register under regce.
  logic [RW-1:0] m_mem [16];
  logic [RW-1:0] m_latch;
  logic [RW-1:0] m_oreg;
  always @(posedge clk_i) begin
    if (bram_en) begin
      if (bram_we) m_mem[bram_addr] <= bram_din;
      else         m_latch <= m_mem[bram_addr];
    end
    if (!bram_rstn)      m_oreg <= '0;
    else if (bram_regce) m_oreg <= m_latch;
  end
  assign bram_dout = m_oreg;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AL-1:0] a, input logic [RW-1:0] d);
    u_if.req_valid = v;
    u_if.req_we    = we;
    u_if.req_addr  = a;
    u_if.req_wdata = d;
  endtask

  logic [RW-1:0] ref_mem [16];
  logic [RW-1:0] exp_q [$];
  mem_req_t      t4 [4];

  initial begin
    logic [AL-1:0] a;
    logic          exp_rdy;
    int            idx;
    logic          prev_hold;
    logic [RW-1:0] prev_dat;

    drive(1'b1, 1'b0, 4'd0, '0);
    u_if.rsp_ready = 1'b0;

    // ---- reset: outputs quiet, request gated even with req_valid high
    tick(); tick();
    settle();
    check("rst_req_ready", u_if.req_ready, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_rsp_valid", u_if.rsp_valid, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_regce", bram_regce, 0);
    check("rst_bram_rstn", bram_rstn, 0);
    drive(1'b0, 1'b0, 4'd0, '0);
    tick();
    rstn = 1'b1;
    u_if.rsp_ready = 1'b1;

    // ---- 1: write 3 = DEADBEEF, read 3, 3-cycle latency
    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
    settle();
    check("t1_wr_ready", u_if.req_ready, 1);
    check("t1_wr_en", bram_en, 1);
    check("t1_wr_we", bram_we, 1);
    check("t1_wr_addr", 32'(bram_addr), 3);
    check("t1_wr_din", bram_din, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 4'd3, '0);
    settle();
    check("t1_rd_en", bram_en, 1);
    check("t1_rd_we", bram_we, 0);
    tick();                                   // T+1
    drive(1'b0, 1'b0, 4'd0, '0);
    settle();
    check("t1_t1_regce", bram_regce, 1);
    check("t1_t1_busy", u_if.busy, 1);
    check("t1_t1_valid", u_if.rsp_valid, 0);
    check("t1_idle_en", bram_en, 0);
    tick(); settle();                         // T+2
    check("t1_t2_valid", u_if.rsp_valid, 0);
    check("t1_t2_regce", bram_regce, 0);
    tick(); settle();                         // T+3
    check("t1_t3_valid", u_if.rsp_valid, 1);
    check("t1_t3_data", u_if.rsp_rdata, 32'hDEADBEEF);
    tick(); settle();                         // T+4
    check("t1_t4_valid", u_if.rsp_valid, 0);
    check("t1_t4_busy", u_if.busy, 0);
    tick();

    // ---- preload addr i = i*0x11 with back-to-back writes
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AL'(i), 32'(i) * 32'h11);
      settle();
      check("pre_wr_ready", u_if.req_ready, 1);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, '0);
    settle();
    check("pre_busy", u_if.busy, 0);
    tick();

    // ---- 2: reads 0..15 back to back, rsp_ready=1
    for (int k = 0; k < 20; k++) begin
      if (k < 16) drive(1'b1, 1'b0, AL'(k), '0);
      else        drive(1'b0, 1'b0, 4'd0, '0);
      settle();
      if (k < 16) check("t2_req_ready", u_if.req_ready, 1);
      if (k >= 3 && k < 19) begin
        check("t2_valid", u_if.rsp_valid, 1);
        check("t2_data", u_if.rsp_rdata, 32'(k - 3) * 32'h11);
      end else begin
        check("t2_valid_idle", u_if.rsp_valid, 0);
      end
      tick();
    end

    // ---- 3: reads 0..7 with rsp_ready=0 until cycle 8
    a = '0;
    idx = 0;
    for (int k = 0; k < 18; k++) begin
      u_if.rsp_ready = (k >= 8);
      exp_rdy = (k <= 3) || (k >= 9);
      if (idx < 8) drive(1'b1, 1'b0, a, '0);
      else         drive(1'b0, 1'b0, 4'd0, '0);
      settle();
      if (idx < 8) check("t3_req_ready", u_if.req_ready, exp_rdy);
      if (k >= 3 && k <= 8) begin
        check("t3_hold_valid", u_if.rsp_valid, 1);
        check("t3_hold_data", u_if.rsp_rdata, 32'h0);
      end else if (k >= 9 && k <= 15) begin
        check("t3_valid", u_if.rsp_valid, 1);
        check("t3_data", u_if.rsp_rdata, 32'(k - 8) * 32'h11);
      end else begin
        check("t3_valid_idle", u_if.rsp_valid, 0);
      end
      if (idx < 8 && exp_rdy) begin
        a = a + 1'b1;
        idx++;
      end
      tick();
    end
    check("t3_busy_end", u_if.busy, 0);

    // ---- 4: W5=1, R5, W5=2, R5 on consecutive cycles
    t4[0] = '{we: 1'b1, addr: 4'd5, wdata: 32'h1};
    t4[1] = '{we: 1'b0, addr: 4'd5, wdata: 32'h0};
    t4[2] = '{we: 1'b1, addr: 4'd5, wdata: 32'h2};
    t4[3] = '{we: 1'b0, addr: 4'd5, wdata: 32'h0};
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, t4[k].we, t4[k].addr, t4[k].wdata);
      else       drive(1'b0, 1'b0, 4'd0, '0);
      settle();
      if (k < 4) check("t4_req_ready", u_if.req_ready, 1);
      if (k == 4) begin
        check("t4_rsp0_valid", u_if.rsp_valid, 1);
        check("t4_rsp0_data", u_if.rsp_rdata, 32'h1);
      end
      if (k == 5) check("t4_gap_valid", u_if.rsp_valid, 0);
      if (k == 6) begin
        check("t4_rsp1_valid", u_if.rsp_valid, 1);
        check("t4_rsp1_data", u_if.rsp_rdata, 32'h2);
      end
      if (k == 7) check("t4_busy_end", u_if.busy, 0);
      tick();
    end

    // ---- 5: reset while two reads are in flight
    drive(1'b1, 1'b0, 4'd9, '0);
    tick();
    drive(1'b1, 1'b0, 4'd10, '0);
    tick();
    rstn = 1'b0;                              // first read is at T+2 here
    drive(1'b1, 1'b0, 4'd11, '0);
    settle();
    check("t5_rst_valid", u_if.rsp_valid, 0);
    check("t5_rst_busy", u_if.busy, 0);
    check("t5_rst_regce", bram_regce, 0);
    check("t5_rst_ready", u_if.req_ready, 0);
    check("t5_rst_en", bram_en, 0);
    tick(); settle();
    check("t5_rst2_valid", u_if.rsp_valid, 0);
    check("t5_rst2_regce", bram_regce, 0);
    tick();
    rstn = 1'b1;
    drive(1'b0, 1'b0, 4'd0, '0);
    for (int k = 0; k < 6; k++) begin
      settle();
      check("t5_post_valid", u_if.rsp_valid, 0);
      check("t5_post_busy", u_if.busy, 0);
      tick();
    end

    // ---- 6: random traffic against a reference memory
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i) * 32'h11;
    ref_mem[5] = 32'h2;
    prev_hold = 1'b0;
    prev_dat  = '0;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AL'($urandom_range(0, 15)), $urandom);
      u_if.rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      if (prev_hold) begin
        check("t6_hold_valid", u_if.rsp_valid, 1);
        check("t6_hold_data", u_if.rsp_rdata, prev_dat);
      end
      if (u_if.req_valid && u_if.req_ready) begin
        if (u_if.req_we) ref_mem[u_if.req_addr] = u_if.req_wdata;
        else             exp_q.push_back(ref_mem[u_if.req_addr]);
      end
      if (u_if.rsp_valid && u_if.rsp_ready) begin
        check("t6_rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("t6_data", u_if.rsp_rdata, exp_q.pop_front());
      end
      prev_hold = u_if.rsp_valid && !u_if.rsp_ready;
      prev_dat  = u_if.rsp_rdata;
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, '0);
    u_if.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      settle();
      if (u_if.rsp_valid) check("t6_drain_data", u_if.rsp_rdata, exp_q.pop_front());
      tick();
    end
    settle();
    check("t6_queue_empty", 32'(exp_q.size()), 0);
    check("t6_busy_end", u_if.busy, 0);
    check("t6_valid_end", u_if.rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
